subleq_sequencer: RTL and testbench
===================================

// Module: subleq_sequencer
// PURPOSE
//   Control FSM that drives the SUBLEQ datapath subtractor (the SHOW_DATA / LEQ_FLAG consumer side).
//   Fetches instruction words a, b, c from unified memory, then loads mem[a] and mem[b].
//   Presents them to the subtractor, writes mem[b] - mem[a] back to mem[b], and branches to c when LEQ_FLAG=1.
//   Sits between program/data memory and the subtractor block.
// PARAMETERS
//   DATA_WIDTH  8     width of data words, addresses and PC (one word = one address)
//   RESET_PC    0     PC value loaded on reset
// PORTS
//   CLK          in   1           rising-edge clock; single clock domain
//   RST          in   1           synchronous, active-high reset
//   START        in   1           begin execution; sampled in IDLE only
//   MEM_ADDR     out  DATA_WIDTH  memory address
//   MEM_RD_EN    out  1           read request; held until MEM_READY=1
//   MEM_WR_EN    out  1           write request; held until MEM_READY=1
//   MEM_WDATA    out  DATA_WIDTH  write data
//   MEM_RDATA    in   DATA_WIDTH  read data; valid in the cycle MEM_READY=1 with MEM_RD_EN=1
//   MEM_READY    in   1           access completes in this cycle
//   SUB_A        out  DATA_WIDTH  to subtractor DATA_A (minuend = mem[b])
//   SUB_B        out  DATA_WIDTH  to subtractor DATA_B (subtrahend = mem[a])
//   SUB_SHOW     out  1           to subtractor SHOW_DATA
//   SUB_DIFF     in   DATA_WIDTH  from subtractor DATA_OUT (tristate bus)
//   SUB_LEQ      in   1           from subtractor LEQ_FLAG (SUB_A <= SUB_B, unsigned)
//   PC_OUT       out  DATA_WIDTH  current PC
//   BUSY         out  1           high in any state except IDLE and HALTED
//   HALT         out  1           high in HALTED
//   RETIRE       out  1           1-cycle pulse when an instruction completes (PC updated)
// BEHAVIOUR
//   Reset: state=IDLE, PC=RESET_PC, all strobes 0, MEM_ADDR/MEM_WDATA/SUB_A/SUB_B=0, HALT=BUSY=RETIRE=0.
//   RST wins over every other event, including a mid-instruction reset:
//     in WRITE, no write completes on or after the reset edge; operand registers are cleared.
//   States and transitions (memory states advance only on MEM_READY=1, otherwise address/enable held):
//     IDLE   : START=1 -> FETCH_A
//     FETCH_A: rd PC      -> latch A_ADDR -> FETCH_B
//     FETCH_B: rd PC+1    -> latch B_ADDR -> FETCH_C
//     FETCH_C: rd PC+2    -> latch C_ADDR -> LOAD_A
//     LOAD_A : rd A_ADDR  -> latch SUB_B  -> LOAD_B
//     LOAD_B : rd B_ADDR  -> latch SUB_A  -> EXEC
//     EXEC   : SUB_SHOW=1 for exactly 1 cycle; latch SUB_DIFF and SUB_LEQ at end of cycle -> WRITE
//     WRITE  : wr B_ADDR <= latched diff; on MEM_READY:
//              if LEQ=1 & C_ADDR=all-ones -> HALTED (PC unchanged, RETIRE=1)
//              elif LEQ=1 -> PC=C_ADDR, RETIRE=1 -> FETCH_A
//              else       -> PC=PC+3,   RETIRE=1 -> FETCH_A
//     HALTED : terminal; only RST exits. START ignored.
//   SUB_SHOW=0 in all states except EXEC; this block never reads SUB_DIFF outside EXEC.
//   MEM_RD_EN and MEM_WR_EN are never high together.
//   All PC arithmetic (PC+1, PC+2, PC+3) is modulo 2^DATA_WIDTH.
//   START outside IDLE is ignored; MEM_READY outside an access is ignored.
//   Latency with MEM_READY tied high: 7 cycles per instruction (FETCH_A..WRITE), back-to-back.
//   Each MEM_READY=0 cycle adds exactly one cycle.
// TESTING
//   1 Reset: assert RST 2 cycles -> PC_OUT=0x00, BUSY=0, HALT=0, RETIRE=0, SUB_SHOW=0, RD/WR_EN=0.
//   2 Non-branch: mem[0..2]={10,11,06}, mem[10]=3, mem[11]=5, READY=1, START pulse
//       -> reads 00,01,02,10,11; SUB_SHOW in cycle 6; write mem[11]=02 in cycle 7; RETIRE; PC=03.
//   3 Branch + halt: mem[0..2]={10,11,FF}, mem[10]=5, mem[11]=5
//       -> write mem[11]=00; HALT=1, BUSY=0, PC=00; no further RD/WR_EN; START ignored.
//   4 Branch/wrap: RESET_PC=FE, instr at FE,FF,00 = {10,11,40}, mem[10]=7, mem[11]=2
//       -> fetch addrs FE,FF,00; write mem[11]=FB; LEQ=1 -> PC=40.
//      Repeat with mem[11]=9 -> mem[11]=02, PC=01.
//   5 Stall: MEM_READY=0 for 3 cycles during LOAD_B
//       -> MEM_ADDR=11 and RD_EN held steady; instruction takes 10 cycles; result as in test 2.
//   6 Reset mid-op: assert RST in WRITE cycle with READY=0
//       -> next cycle WR_EN=0, state IDLE, PC=RESET_PC; memory unchanged.

Source files
------------

// File: rtl/subleq_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : subleq_sequencer_if
// Description : Memory and subtractor bus seen by the SUBLEQ control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface subleq_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] sub_a;
    logic [DATA_WIDTH-1:0] sub_b;
    logic                  sub_show;
    logic [DATA_WIDTH-1:0] sub_diff;
    logic                  sub_leq;
    logic [DATA_WIDTH-1:0] pc_out;
    logic                  busy;
    logic                  halt;
    logic                  retire;

    // Sequencer side: masters the memory bus and drives the subtractor operands.
    modport master (
        input  start, mem_rdata, mem_ready, sub_diff, sub_leq,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output sub_a, sub_b, sub_show, pc_out, busy, halt, retire
    );

    // Environment side: memory, subtractor and the controlling host.
    modport slave (
        output start, mem_rdata, mem_ready, sub_diff, sub_leq,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  sub_a, sub_b, sub_show, pc_out, busy, halt, retire
    );
endinterface
`default_nettype wire

// File: rtl/subleq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : subleq_sequencer
// Description : Fetch/load/execute/write-back control FSM for a SUBLEQ machine.
// Revision    : 1.0 - initial release
// ============================================================================
module subleq_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst,
    subleq_sequencer_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] c_ONE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_TWO      = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] c_THREE    = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] c_ALL_ONES = '1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_B = 4'd2,
        S_FETCH_C = 4'd3,
        S_LOAD_A  = 4'd4,
        S_LOAD_B  = 4'd5,
        S_EXEC    = 4'd6,
        S_WRITE   = 4'd7,
        S_HALTED  = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_a_addr;
    logic [DATA_WIDTH-1:0] r_b_addr;
    logic [DATA_WIDTH-1:0] r_c_addr;
    logic [DATA_WIDTH-1:0] r_sub_a;
    logic [DATA_WIDTH-1:0] r_sub_b;
    logic [DATA_WIDTH-1:0] r_diff;
    logic                  r_leq;
    logic                  r_retire;

    logic [DATA_WIDTH-1:0] w_addr;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_show;
    logic                  w_retire_nxt;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic                  w_rd_done;

    assign w_rd_done = w_rd_en & bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_sub_a  <= '0;
            r_sub_b  <= '0;
            r_diff   <= '0;
            r_leq    <= 1'b0;
            r_retire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_retire <= w_retire_nxt;
            r_pc     <= w_pc_nxt;
            if (w_rd_done) begin
                case (r_state)
                    S_FETCH_A: r_a_addr <= bus.mem_rdata;
                    S_FETCH_B: r_b_addr <= bus.mem_rdata;
                    S_FETCH_C: r_c_addr <= bus.mem_rdata;
                    S_LOAD_A:  r_sub_b  <= bus.mem_rdata;
                    S_LOAD_B:  r_sub_a  <= bus.mem_rdata;
                    default: ;
                endcase
            end
            if (r_state == S_EXEC) begin
                r_diff <= bus.sub_diff;
                r_leq  <= bus.sub_leq;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr       = '0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_wdata      = '0;
        w_show       = 1'b0;
        w_retire_nxt = 1'b0;
        w_pc_nxt     = r_pc;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH_A;
            end
            S_FETCH_A: begin
                w_addr  = r_pc;
                w_rd_en = 1'b1;
                if (bus.mem_ready) w_state_nxt = S_FETCH_B;
            end
            S_FETCH_B: begin
                w_addr  = r_pc + c_ONE;
                w_rd_en = 1'b1;
                if (bus.mem_ready) w_state_nxt = S_FETCH_C;
            end
            S_FETCH_C: begin
                w_addr  = r_pc + c_TWO;
                w_rd_en = 1'b1;
                if (bus.mem_ready) w_state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                w_addr  = r_a_addr;
                w_rd_en = 1'b1;
                if (bus.mem_ready) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_addr  = r_b_addr;
                w_rd_en = 1'b1;
                if (bus.mem_ready) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_show      = 1'b1;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_addr  = r_b_addr;
                w_wr_en = 1'b1;
                w_wdata = r_diff;
                if (bus.mem_ready) begin
                    w_retire_nxt = 1'b1;
                    // A taken branch to the all-ones address is the halt idiom.
                    if (r_leq && (r_c_addr == c_ALL_ONES)) begin
                        w_state_nxt = S_HALTED;
                    end else if (r_leq) begin
                        w_pc_nxt    = r_c_addr;
                        w_state_nxt = S_FETCH_A;
                    end else begin
                        w_pc_nxt    = r_pc + c_THREE;
                        w_state_nxt = S_FETCH_A;
                    end
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are masked by reset so no access can complete on the reset edge.
    assign bus.mem_addr  = w_addr;
    assign bus.mem_rd_en = w_rd_en & ~rst;
    assign bus.mem_wr_en = w_wr_en & ~rst;
    assign bus.mem_wdata = w_wdata;
    assign bus.sub_a     = r_sub_a;
    assign bus.sub_b     = r_sub_b;
    assign bus.sub_show  = w_show;
    assign bus.pc_out    = r_pc;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign bus.halt      = (r_state == S_HALTED);
    assign bus.retire    = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_subleq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_subleq_sequencer
// Description : Directed and random SUBLEQ programs checked against an
//               instruction-level reference interpreter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subleq_sequencer;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subleq_sequencer_if #(.DATA_WIDTH(DW)) bus ();
    subleq_sequencer_if #(.DATA_WIDTH(DW)) bus_fe ();

    subleq_sequencer #(.DATA_WIDTH(DW), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    subleq_sequencer #(.DATA_WIDTH(DW), .RESET_PC(8'hFE)) dut_fe (
        .clk (clk),
        .rst (rst),
        .bus (bus_fe)
    );

    logic [7:0] mem  [256];
    logic [7:0] mmem [256];
    logic [7:0] img  [256];
    int         total = 0;
    int         bad   = 0;

    int         step;
    bit         ret_due;
    logic [7:0] m_pc;
    bit         m_halt;
    bit         load_img;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory and subtractor behaviour seen by the sequencer.
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.sub_diff  = bus.sub_show ? (bus.sub_a - bus.sub_b) : '0;
    assign bus.sub_leq   = (bus.sub_a <= bus.sub_b);

    assign bus_fe.mem_rdata = '0;
    assign bus_fe.mem_ready = 1'b0;
    assign bus_fe.sub_diff  = '0;
    assign bus_fe.sub_leq   = 1'b0;

    // Reference: one SUBLEQ instruction = 5 reads, 1 write, then PC update.
    always @(negedge clk) begin : p_mon
        logic [7:0] pc1, pc2, ia, ib, ic, va, vb, exp_addr;
        bit         wr_done;
        if (rst) begin
            step    = 0;
            ret_due = 0;
            m_pc    = 8'h00;
            m_halt  = 0;
            if (load_img) begin
                for (int i = 0; i < 256; i++) begin
                    mem[i]  = img[i];
                    mmem[i] = img[i];
                end
            end
        end else begin
            pc1     = m_pc + 8'd1;
            pc2     = m_pc + 8'd2;
            ia      = mmem[m_pc];
            ib      = mmem[pc1];
            ic      = mmem[pc2];
            va      = mmem[ia];
            vb      = mmem[ib];
            wr_done = 0;
            check_eq("retire", bus.retire, ret_due);
            if (ret_due) begin
                check_eq("pc_after_retire", bus.pc_out, m_pc);
                check_eq("busy_after_retire", bus.busy, !m_halt);
            end
            check_eq("halt", bus.halt, m_halt);
            check_eq("rd_wr_excl", bus.mem_rd_en & bus.mem_wr_en, 0);
            if (bus.sub_show) begin
                check_eq("show_step", step, 5);
                check_eq("sub_a", bus.sub_a, vb);
                check_eq("sub_b", bus.sub_b, va);
            end
            if (bus.mem_rd_en && bus.mem_ready) begin
                case (step)
                    0: exp_addr = m_pc;
                    1: exp_addr = pc1;
                    2: exp_addr = pc2;
                    3: exp_addr = ia;
                    4: exp_addr = ib;
                    default: begin
                        exp_addr = 8'h00;
                        check_eq("rd_step", step, 4);
                    end
                endcase
                check_eq("rd_addr", bus.mem_addr, exp_addr);
                step++;
            end
            if (bus.mem_wr_en && bus.mem_ready) begin
                check_eq("wr_step", step, 5);
                check_eq("wr_addr", bus.mem_addr, ib);
                check_eq("wr_data", bus.mem_wdata, 8'(vb - va));
                mem[bus.mem_addr] = bus.mem_wdata;
                mmem[ib] = vb - va;
                if (vb <= va && ic == 8'hFF) m_halt = 1;
                else if (vb <= va)           m_pc = ic;
                else                         m_pc = m_pc + 8'd3;
                step    = 0;
                wr_done = 1;
            end
            ret_due = wr_done;
        end
    end

    task automatic do_reset(input bit reload);
        load_img      = reload;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        load_img = 1'b1;
    endtask

    // Pulses START and clocks until n_ret retires or halt; reports cycle of first retire.
    task automatic run(input int n_ret, input int st_at, input int st_len, input bit rnd,
                       output int first);
        int n   = 0;
        int ret = 0;
        bit stall;
        first     = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        while (ret < n_ret && !bus.halt && n < 3000) begin
            n++;
            stall = (n >= st_at) && (n < st_at + st_len);
            bus.mem_ready = rnd ? ($urandom_range(0, 3) != 0) : !stall;
            @(negedge clk);
            if (stall) begin
                check_eq("stall_addr", bus.mem_addr, 8'h11);
                check_eq("stall_rd_en", bus.mem_rd_en, 1);
            end
            if (bus.retire) begin
                ret++;
                if (ret == 1) first = n;
            end
            @(posedge clk);
            #1;
        end
        if (n >= 3000) check_eq("run_timeout", n, 0);
        bus.mem_ready = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic load_basic(input logic [7:0] c_word, input logic [7:0] va, input logic [7:0] vb);
        clear_img();
        img[0] = 8'h10; img[1] = 8'h11; img[2] = c_word;
        img[8'h10] = va; img[8'h11] = vb;
    endtask

    initial begin
        int lat;
        int seen;
        int diffs;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        bus_fe.start = 1'b0;
        load_img = 1'b1;
        load_basic(8'h06, 8'd3, 8'd5);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_pc", bus.pc_out, 8'h00);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_halt", bus.halt, 0);
        check_eq("rst_retire", bus.retire, 0);
        check_eq("rst_show", bus.sub_show, 0);
        check_eq("rst_rdwr", {bus.mem_rd_en, bus.mem_wr_en}, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_ops", {bus.sub_a, bus.sub_b, bus.mem_wdata}, 0);
        check_eq("fe_rst_pc", bus_fe.pc_out, 8'hFE);
        @(posedge clk);
        #1;
        bus_fe.start = 1'b1;
        @(posedge clk);
        #1;
        bus_fe.start = 1'b0;
        @(negedge clk);
        check_eq("fe_fetch_addr", bus_fe.mem_addr, 8'hFE);
        check_eq("fe_fetch_rd", bus_fe.mem_rd_en, 1);
        @(posedge clk);
        #1;

        // Non-branch instruction with zero-wait memory
        run(1, 0, 0, 0, lat);
        check_eq("t2_latency", lat, 8);
        check_eq("t2_mem11", mem[8'h11], 8'h02);
        check_eq("t2_pc", bus.pc_out, 8'h03);

        // Stall of three cycles in LOAD_B
        do_reset(1);
        run(1, 5, 3, 0, lat);
        check_eq("t5_latency", lat, 11);
        check_eq("t5_mem11", mem[8'h11], 8'h02);

        // Taken branch to all-ones halts
        load_basic(8'hFF, 8'd5, 8'd5);
        do_reset(1);
        run(1, 0, 0, 0, lat);
        check_eq("t3_halt", bus.halt, 1);
        check_eq("t3_busy", bus.busy, 0);
        check_eq("t3_pc", bus.pc_out, 8'h00);
        check_eq("t3_mem11", mem[8'h11], 8'h00);
        seen = 0;
        bus.start = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | int'(bus.mem_rd_en) | int'(bus.mem_wr_en);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check_eq("t3_no_access", seen, 0);
        check_eq("t3_still_halt", bus.halt, 1);

        // PC wrap: jump to FE, then an instruction spanning FE,FF,00
        for (int v = 0; v < 2; v++) begin
            clear_img();
            img[0] = 8'h40; img[1] = 8'h40; img[2] = 8'hFE; img[8'h40] = 8'h33;
            img[8'hFE] = 8'h10; img[8'hFF] = 8'h11;
            img[8'h10] = 8'd7; img[8'h11] = (v == 0) ? 8'd2 : 8'd9;
            do_reset(1);
            run(2, 0, 0, 0, lat);
            check_eq("t4_pc", bus.pc_out, (v == 0) ? 8'h40 : 8'h01);
            check_eq("t4_mem11", mem[8'h11], (v == 0) ? 8'hFB : 8'h02);
        end

        // Reset arriving in WRITE while the write is stalled
        load_basic(8'h06, 8'd3, 8'd5);
        do_reset(1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            bus.mem_ready = (n < 7);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        check_eq("t6_in_write", bus.mem_wr_en, 1);
        rst = 1'b1;
        load_img = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_wr_masked", bus.mem_wr_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_img = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("t6_busy", bus.busy, 0);
        check_eq("t6_pc", bus.pc_out, 8'h00);
        check_eq("t6_wr_en", bus.mem_wr_en, 0);
        check_eq("t6_mem11", mem[8'h11], 8'h05);
        @(posedge clk);
        #1;

        // Random programs with random wait states and random reset points
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            do_reset(1);
            run(20, 0, 0, 1, lat);
            repeat ($urandom_range(0, 9)) begin
                bus.mem_ready = ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
            end
            bus.mem_ready = 1'b0;
            diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) diffs++;
            check_eq("rand_mem_image", diffs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
